// File: rtl/mem_bus_arbiter_pkg.sv
// Shared bus definitions for the processor-to-memory arbiter slice:
// bus commands, memory geometry and the tag-owner encoding.
package mem_bus_arbiter_pkg;

  localparam int NUM_MEM_TAGS = 15;
  localparam int DATA_SIZE    = 64;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  typedef enum logic {
    OWNER_DC = 1'b0,
    OWNER_IC = 1'b1
  } MEM_OWNER;

endpackage

// File: rtl/mem_bus_arbiter_tag_owner.sv
// Per-tag owner table: remembers which cache issued each outstanding load
// so returning tags are steered back to it; flags returns with no owner.
module mem_tag_owner_table
  import mem_bus_arbiter_pkg::*;
#(
  parameter int NUM_TAGS = NUM_MEM_TAGS,
  parameter int TAG_W    = $clog2(NUM_TAGS + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             alloc_en,
  input  logic [TAG_W-1:0] alloc_tag,
  input  MEM_OWNER         alloc_owner,
  input  logic [TAG_W-1:0] ret_tag,
  output logic [TAG_W-1:0] dc_tag,
  output logic [TAG_W-1:0] ic_tag,
  output logic             orphan_err
);

  logic [NUM_TAGS-1:0] valid;
  MEM_OWNER            owner [NUM_TAGS];
  logic                hit;
  MEM_OWNER            hit_owner;

  // Lookup uses the table contents before this edge, so a same-cycle
  // clear/allocate still routes the returning tag to its previous owner.
  always_comb begin
    hit       = 1'b0;
    hit_owner = OWNER_DC;
    for (int i = 0; i < NUM_TAGS; i++) begin
      if (ret_tag == TAG_W'(i + 1)) begin
        hit       = valid[i] && reset;
        hit_owner = owner[i];
      end
    end
    dc_tag = (hit && hit_owner == OWNER_DC) ? ret_tag : '0;
    ic_tag = (hit && hit_owner == OWNER_IC) ? ret_tag : '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid      <= '0;
      orphan_err <= 1'b0;
      for (int i = 0; i < NUM_TAGS; i++) owner[i] <= OWNER_DC;
    end else begin
      for (int i = 0; i < NUM_TAGS; i++) begin
        if (alloc_en && alloc_tag == TAG_W'(i + 1)) begin
          valid[i] <= 1'b1;
          owner[i] <= alloc_owner;
        end else if (ret_tag == TAG_W'(i + 1)) begin
          valid[i] <= 1'b0;
        end
      end
      if (ret_tag != '0 && !hit) orphan_err <= 1'b1;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single memory bus between dcache and icache, with dcache
// priority and a starvation counter that eventually forces an icache grant.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int NUM_TAGS     = NUM_MEM_TAGS,
  parameter int TAG_W        = $clog2(NUM_TAGS + 1),
  parameter int DATA_W       = DATA_SIZE,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  BUS_COMMAND        dc2mem_command,
  input  logic [31:0]       dc2mem_addr,
  input  logic [DATA_W-1:0] dc2mem_data,
  input  BUS_COMMAND        ic2mem_command,
  input  logic [31:0]       ic2mem_addr,
  input  logic [TAG_W-1:0]  mem2proc_response,
  input  logic [DATA_W-1:0] mem2proc_data,
  input  logic [TAG_W-1:0]  mem2proc_tag,
  output BUS_COMMAND        proc2mem_command,
  output logic [31:0]       proc2mem_addr,
  output logic [DATA_W-1:0] proc2mem_data,
  output logic [TAG_W-1:0]  mem2dc_response,
  output logic [DATA_W-1:0] mem2dc_data,
  output logic [TAG_W-1:0]  mem2dc_tag,
  output logic [TAG_W-1:0]  mem2ic_response,
  output logic [DATA_W-1:0] mem2ic_data,
  output logic [TAG_W-1:0]  mem2ic_tag,
  output logic              orphan_tag_err
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  logic [STARVE_W-1:0] starve_cnt;
  logic                dc_req;
  logic                ic_req;
  logic                grant_dc;
  logic                grant_ic;
  logic                accepted;
  logic                alloc_en;
  MEM_OWNER            alloc_owner;

  always_comb begin
    dc_req   = dc2mem_command != BUS_NONE;
    ic_req   = ic2mem_command != BUS_NONE;
    grant_ic = ic_req && (!dc_req || starve_cnt == STARVE_W'(STARVE_LIMIT));
    grant_dc = dc_req && !grant_ic;
    accepted = mem2proc_response != '0;

    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    if (grant_ic) begin
      proc2mem_command = ic2mem_command;
      proc2mem_addr    = ic2mem_addr;
    end else if (grant_dc) begin
      proc2mem_command = dc2mem_command;
      proc2mem_addr    = dc2mem_addr;
      proc2mem_data    = dc2mem_data;
    end

    // The losing side sees a rejection and simply retries next cycle.
    mem2dc_response = grant_dc ? mem2proc_response : '0;
    mem2ic_response = grant_ic ? mem2proc_response : '0;
    mem2dc_data     = mem2proc_data;
    mem2ic_data     = mem2proc_data;

    alloc_en    = (proc2mem_command == BUS_LOAD) && accepted;
    alloc_owner = grant_ic ? OWNER_IC : OWNER_DC;
  end

  // A forced grant that memory rejects leaves the count at the limit so
  // the icache keeps the bus until memory accepts its request.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (!ic_req) begin
      starve_cnt <= '0;
    end else if (grant_ic) begin
      if (accepted) starve_cnt <= '0;
    end else if (starve_cnt != STARVE_W'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  mem_tag_owner_table #(
    .NUM_TAGS (NUM_TAGS),
    .TAG_W    (TAG_W)
  ) u_owner_table (
    .clock       (clock),
    .reset       (reset),
    .alloc_en    (alloc_en),
    .alloc_tag   (mem2proc_response),
    .alloc_owner (alloc_owner),
    .ret_tag     (mem2proc_tag),
    .dc_tag      (mem2dc_tag),
    .ic_tag      (mem2ic_tag),
    .orphan_err  (orphan_tag_err)
  );

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: a driver feeds directed and random
// cycles through a behavioural model, a monitor compares DUT outputs.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  localparam int LIMIT = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  BUS_COMMAND  dc2mem_command = BUS_NONE;
  logic [31:0] dc2mem_addr = '0;
  logic [63:0] dc2mem_data = '0;
  BUS_COMMAND  ic2mem_command = BUS_NONE;
  logic [31:0] ic2mem_addr = '0;
  logic [3:0]  mem2proc_response = '0;
  logic [63:0] mem2proc_data = '0;
  logic [3:0]  mem2proc_tag = '0;
  BUS_COMMAND  proc2mem_command;
  logic [31:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [3:0]  mem2dc_response, mem2dc_tag, mem2ic_response, mem2ic_tag;
  logic [63:0] mem2dc_data, mem2ic_data;
  logic        orphan_tag_err;

  mem_bus_arbiter dut (
    .clock             (clock),
    .reset             (reset),
    .dc2mem_command    (dc2mem_command),
    .dc2mem_addr       (dc2mem_addr),
    .dc2mem_data       (dc2mem_data),
    .ic2mem_command    (ic2mem_command),
    .ic2mem_addr       (ic2mem_addr),
    .mem2proc_response (mem2proc_response),
    .mem2proc_data     (mem2proc_data),
    .mem2proc_tag      (mem2proc_tag),
    .proc2mem_command  (proc2mem_command),
    .proc2mem_addr     (proc2mem_addr),
    .proc2mem_data     (proc2mem_data),
    .mem2dc_response   (mem2dc_response),
    .mem2dc_data       (mem2dc_data),
    .mem2dc_tag        (mem2dc_tag),
    .mem2ic_response   (mem2ic_response),
    .mem2ic_data       (mem2ic_data),
    .mem2ic_tag        (mem2ic_tag),
    .orphan_tag_err    (orphan_tag_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  cmd;
    logic [31:0] addr;
    logic [63:0] data;
    logic [3:0]  dc_resp;
    logic [3:0]  ic_resp;
    logic [63:0] dc_data;
    logic [63:0] ic_data;
    logic [3:0]  dc_tag;
    logic [3:0]  ic_tag;
    logic        orphan;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  // Reference model state: outstanding tags mapped to owner (0 dc, 1 ic).
  int owner_of[int];
  int starve = 0;
  bit orphan_m = 1'b0;

  task automatic apply_stimulus(input BUS_COMMAND dcc, input logic [31:0] dca,
                                input logic [63:0] dcd, input BUS_COMMAND icc,
                                input logic [31:0] ica, input logic [3:0] resp,
                                input logic [3:0] rtag, input logic [63:0] rdata,
                                input logic rst);
    exp_t e;
    bit   dc_req, ic_req, g_ic, g_dc;
    @(negedge clock);
    cycle++;
    reset = rst;
    dc2mem_command = dcc;
    dc2mem_addr = dca;
    dc2mem_data = dcd;
    ic2mem_command = icc;
    ic2mem_addr = ica;
    mem2proc_response = resp;
    mem2proc_tag = rtag;
    mem2proc_data = rdata;
    if (!rst) begin
      owner_of.delete();
      starve = 0;
      orphan_m = 1'b0;
    end
    dc_req = (dcc != BUS_NONE);
    ic_req = (icc != BUS_NONE);
    g_ic = ic_req && (!dc_req || starve >= LIMIT);
    g_dc = dc_req && !g_ic;
    e.cmd = g_ic ? 2'(icc) : (g_dc ? 2'(dcc) : 2'(BUS_NONE));
    e.addr = g_ic ? ica : (g_dc ? dca : 32'h0);
    e.data = g_dc ? dcd : 64'h0;
    e.dc_resp = g_dc ? resp : 4'h0;
    e.ic_resp = g_ic ? resp : 4'h0;
    e.dc_data = rdata;
    e.ic_data = rdata;
    e.dc_tag = 4'h0;
    e.ic_tag = 4'h0;
    if (rtag != 0 && owner_of.exists(int'(rtag))) begin
      if (owner_of[int'(rtag)] == 0) e.dc_tag = rtag;
      else e.ic_tag = rtag;
    end
    e.orphan = orphan_m;
    exp_q.push_back(e);
    // Advance the model to what the coming rising edge should leave behind.
    if (rst) begin
      if (rtag != 0) begin
        if (owner_of.exists(int'(rtag))) owner_of.delete(int'(rtag));
        else orphan_m = 1'b1;
      end
      if (resp != 0 && ((g_ic && icc == BUS_LOAD) || (g_dc && dcc == BUS_LOAD)))
        owner_of[int'(resp)] = g_ic ? 1 : 0;
      if (!ic_req) starve = 0;
      else if (g_ic) begin
        if (resp != 0) starve = 0;
      end else if (starve < LIMIT) starve++;
    end
  endtask

  task automatic check_field(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cycle, act, exp);
    end
  endtask

  task automatic check_output(input exp_t e);
    check_field("proc2mem_command", 64'(proc2mem_command), 64'(e.cmd));
    check_field("proc2mem_addr", 64'(proc2mem_addr), 64'(e.addr));
    check_field("proc2mem_data", proc2mem_data, e.data);
    check_field("mem2dc_response", 64'(mem2dc_response), 64'(e.dc_resp));
    check_field("mem2ic_response", 64'(mem2ic_response), 64'(e.ic_resp));
    check_field("mem2dc_data", mem2dc_data, e.dc_data);
    check_field("mem2ic_data", mem2ic_data, e.ic_data);
    check_field("mem2dc_tag", 64'(mem2dc_tag), 64'(e.dc_tag));
    check_field("mem2ic_tag", 64'(mem2ic_tag), 64'(e.ic_tag));
    check_field("orphan_tag_err", 64'(orphan_tag_err), 64'(e.orphan));
  endtask

  // Monitor: outputs settle after the negedge drive; sample well clear of posedge.
  initial begin
    forever begin
      @(negedge clock);
      #2;
      if (exp_q.size() > 0) check_output(exp_q.pop_front());
    end
  end

  task automatic idle(input logic [3:0] rtag, input logic rst);
    apply_stimulus(BUS_NONE, 32'h0, 64'h0, BUS_NONE, 32'h0, 4'h0, rtag,
                   64'hDEAD_BEEF_0000_0000 | 64'(rtag), rst);
  endtask

  initial begin
    BUS_COMMAND dcc, icc;
    logic [3:0] resp, rtag;
    int         k;

    $display("[TB] start");
    idle(4'h0, 1'b0);
    idle(4'h0, 1'b0);

    // dcache load accepted with tag 3, later returned to dcache.
    apply_stimulus(BUS_LOAD, 32'h100, 64'h11, BUS_NONE, 32'h0, 4'd3, 4'd0, 64'h0, 1'b1);
    idle(4'd0, 1'b1);
    idle(4'd3, 1'b1);

    // Both loading: four dcache wins, then the icache is forced through.
    for (int i = 0; i < 5; i++)
      apply_stimulus(BUS_LOAD, 32'h200 + 32'(i), 64'h22, BUS_LOAD, 32'h4000,
                     4'd5, 4'd0, 64'h0, 1'b1);
    apply_stimulus(BUS_LOAD, 32'h300, 64'h33, BUS_LOAD, 32'h4004, 4'd1, 4'd0, 64'h0, 1'b1);

    // Store never allocates, so its tag coming back is an orphan.
    apply_stimulus(BUS_STORE, 32'h500, 64'h55AA, BUS_NONE, 32'h0, 4'd2, 4'd0, 64'h0, 1'b1);
    idle(4'd2, 1'b1);
    idle(4'd0, 1'b1);
    idle(4'd0, 1'b0);

    // Tag 4 returns to dcache in the same cycle it is reallocated to icache.
    apply_stimulus(BUS_LOAD, 32'h600, 64'h0, BUS_NONE, 32'h0, 4'd4, 4'd0, 64'h0, 1'b1);
    apply_stimulus(BUS_NONE, 32'h0, 64'h0, BUS_LOAD, 32'h4100, 4'd4, 4'd4, 64'h44, 1'b1);
    idle(4'd4, 1'b1);

    // Forced icache grant rejected by memory stays forced.
    for (int i = 0; i < 6; i++)
      apply_stimulus(BUS_LOAD, 32'h700, 64'h77, BUS_LOAD, 32'h4200, 4'd0, 4'd0, 64'h0, 1'b1);
    apply_stimulus(BUS_LOAD, 32'h700, 64'h77, BUS_LOAD, 32'h4200, 4'd7, 4'd0, 64'h0, 1'b1);
    apply_stimulus(BUS_LOAD, 32'h704, 64'h77, BUS_LOAD, 32'h4204, 4'd8, 4'd0, 64'h0, 1'b1);

    // Reset discards outstanding tag 6; its return is an orphan.
    apply_stimulus(BUS_LOAD, 32'h800, 64'h0, BUS_NONE, 32'h0, 4'd6, 4'd0, 64'h0, 1'b1);
    idle(4'd0, 1'b0);
    idle(4'd0, 1'b1);
    idle(4'd6, 1'b1);
    idle(4'd0, 1'b1);
    idle(4'd0, 1'b0);

    for (int n = 0; n < 600; n++) begin
      dcc  = BUS_COMMAND'($urandom_range(0, 2));
      icc  = ($urandom_range(0, 1) == 1) ? BUS_LOAD : BUS_NONE;
      resp = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      case ($urandom_range(0, 3))
        0, 1: rtag = 4'd0;
        2: begin
          if (owner_of.first(k)) rtag = 4'(k);
          else rtag = 4'($urandom_range(1, 15));
        end
        default: rtag = 4'($urandom_range(1, 15));
      endcase
      apply_stimulus(dcc, $urandom, {$urandom, $urandom}, icc, $urandom, resp, rtag,
                     {$urandom, $urandom}, ($urandom_range(0, 79) != 0));
    end

    repeat (2) @(negedge clock);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Sits directly downstream of the data-cache top and the instruction-cache controller. Owns the single processor-to-memory bus.
- Each cycle it grants the bus to one requester and forwards the memory response (the accepted tag) to the granted side only.
- Keeps a per-tag owner table so that returning load data and tags reach the cache that issued the request.
- Data cache has priority; an anti-starvation counter guarantees instruction-fetch progress.

Parameters:
- NUM_TAGS, `NUM_MEM_TAGS (15): number of memory tags. Tag value 0 means "none / rejected".
- TAG_W, $clog2(NUM_TAGS+1): width of the response and tag buses.
- DATA_W, `DATA_SIZE (64): memory data width.
- STARVE_LIMIT, 4: number of consecutive denied icache cycles after which the icache is forced a grant.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- dc2mem_command  in  BUS_COMMAND  dcache request (BUS_NONE/BUS_LOAD/BUS_STORE)
- dc2mem_addr  in  32  dcache address
- dc2mem_data  in  DATA_W  dcache store data
- ic2mem_command  in  BUS_COMMAND  icache request (BUS_NONE/BUS_LOAD only)
- ic2mem_addr  in  32  icache address
- mem2proc_response  in  TAG_W  memory acceptance tag, 0 = rejected
- mem2proc_data  in  DATA_W  returning load data
- mem2proc_tag  in  TAG_W  tag of returning data, 0 = none
- proc2mem_command  out  BUS_COMMAND  granted command
- proc2mem_addr  out  32  granted address
- proc2mem_data  out  DATA_W  granted store data
- mem2dc_response  out  TAG_W  response to dcache
- mem2dc_data  out  DATA_W  data to dcache
- mem2dc_tag  out  TAG_W  tag to dcache
- mem2ic_response  out  TAG_W  response to icache
- mem2ic_data  out  DATA_W  data to icache
- mem2ic_tag  out  TAG_W  tag to icache
- orphan_tag_err  out  1  sticky flag: a tag returned with no owner

Behaviour:
- Grant is combinational, in the same cycle.
  - grant_ic = ic requesting AND (dc idle OR starve_cnt == STARVE_LIMIT).
  - Otherwise the dcache wins whenever its command is not BUS_NONE.
- The granted requester's command, address and data drive proc2mem_*.
  - With no request, proc2mem_command = BUS_NONE and address/data = 0.
- mem2proc_response is routed to the granted side only. The losing side sees response 0 and retries, as it already does on a memory rejection.
- Data is forwarded unconditionally on mem2dc_data and mem2ic_data. mem2dc_tag/mem2ic_tag equal mem2proc_tag when owner[tag] selects that side, else 0.
- Owner table: NUM_TAGS entries, each holding a valid bit and an owner bit (0 = dc, 1 = ic). Indexed by tag-1.
  - Allocate on the clock edge when a BUS_LOAD is granted and mem2proc_response != 0.
  - Stores never allocate.
  - Clear on the edge when mem2proc_tag != 0 and the entry is valid.
  - If the same tag is cleared and allocated in one cycle, allocation wins and the entry stays valid with the new owner.
- Tag return with an invalid entry: both client tags are 0, and orphan_tag_err is set and held until reset.
- starve_cnt (saturating at STARVE_LIMIT):
  - Increments each cycle the icache requests and is not granted.
  - Clears when the icache is granted and memory accepts (response != 0), or when the icache is idle.
  - A forced grant that memory rejects keeps the count at the limit, so the grant is re-forced next cycle.
- Reset (asynchronous, low): all table entries invalid, starve_cnt = 0, orphan_tag_err = 0.
  - Combinational outputs follow the inputs but treat every table entry as invalid, so both client tags are 0.
- Reset mid-operation discards all outstanding ownership; any later returns raise orphan_tag_err.

Decomposition:
- BUS_COMMAND and `NUM_MEM_TAGS / `DATA_SIZE come from the shared sys_defs package.
- Add a shared typedef MEM_OWNER (OWNER_DC = 0, OWNER_IC = 1) to the same package.
- One sub-module is natural: mem_tag_owner_table, covering allocate, clear, lookup and orphan detection. Grant logic and the starvation counter stay in the top.

Test Plan:
- dc BUS_LOAD 0x100, ic idle, response = 3 → proc2mem_addr = 0x100, mem2dc_response = 3, mem2ic_response = 0. Later mem2proc_tag = 3 → mem2dc_tag = 3, mem2ic_tag = 0, and entry 3 is cleared.
- dc and ic both BUS_LOAD, response = 5 → dc granted and ic sees 0. Hold both for 4 more cycles → on the 5th cycle (starve_cnt = 4) ic is granted and gets the response; starve_cnt returns to 0.
- dc BUS_STORE, response = 2 → mem2dc_response = 2 and no table entry. A later mem2proc_tag = 2 → orphan_tag_err = 1 and both client tags are 0.
- Same cycle: mem2proc_tag = 4 returns (owner dc) while an ic load is granted with response = 4 → dc receives tag 4, and entry 4 becomes valid with owner ic.
- Forced ic grant with response = 0 → starve_cnt stays at 4 and ic is granted again the next cycle.
- Issue dc load tag 6, then assert reset (low) before its return, then mem2proc_tag = 6 → no client tag and orphan_tag_err = 1.
